// File: rtl/imem_prefetch_buffer.sv
// In-order instruction prefetch queue between a tagged, variable-latency
// instruction memory port and the IF stage; redirect flushes and restarts fetch.
module imem_prefetch_buffer #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  input  logic             if_ready,
  output logic             out_valid,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_inst,
  output logic [31:0]      proc2Imem_addr,
  output logic [1:0]       proc2Imem_command,
  input  logic [TAG_W-1:0] mem2proc_response,
  input  logic [31:0]      mem2proc_data,
  input  logic [TAG_W-1:0] mem2proc_tag
);

  localparam logic [1:0]       BUS_NONE = 2'd0;
  localparam logic [1:0]       BUS_LOAD = 2'd1;
  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int               CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [31:0]      ent_pc_q   [DEPTH];
  logic [31:0]      ent_pc_d   [DEPTH];
  logic [TAG_W-1:0] ent_tag_q  [DEPTH];
  logic [TAG_W-1:0] ent_tag_d  [DEPTH];
  logic [31:0]      ent_inst_q [DEPTH];
  logic [31:0]      ent_inst_d [DEPTH];
  logic [DEPTH-1:0] ent_vld_q, ent_vld_d;
  logic [DEPTH-1:0] ent_done_q, ent_done_d;

  logic issue;
  logic accept;
  logic pop;
  logic tag_hit;
  logic redirect_pc_unused;

  // Low address bits of a redirect are forced to word alignment.
  assign redirect_pc_unused = ^redirect_pc[1:0];

  // Handshakes: IF takes the head when out_valid && if_ready on a rising edge;
  // memory takes a load when command == BUS_LOAD && response != 0 on that edge;
  // a return is valid whenever mem2proc_tag != 0. Command is gated by reset
  // so that it drops the instant reset asserts.
  assign issue     = rst && !redirect_valid && (count_q < FULL_CNT);
  assign accept    = issue && (mem2proc_response != '0);
  assign out_valid = (count_q != '0) && ent_done_q[head_q];
  assign pop       = out_valid && if_ready;
  assign tag_hit   = (mem2proc_tag != '0);

  assign out_pc            = ent_pc_q[head_q];
  assign out_inst          = ent_inst_q[head_q];
  assign proc2Imem_addr    = fetch_pc_q;
  assign proc2Imem_command = issue ? BUS_LOAD : BUS_NONE;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    ent_pc_d   = ent_pc_q;
    ent_tag_d  = ent_tag_q;
    ent_inst_d = ent_inst_q;
    ent_vld_d  = ent_vld_q;
    ent_done_d = ent_done_q;

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      ent_vld_d  = '0;
      ent_done_d = '0;
    end else begin
      // Only a live, still-pending slot may capture; stale tags fall through.
      if (tag_hit) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (ent_vld_q[i] && !ent_done_q[i] && (ent_tag_q[i] == mem2proc_tag)) begin
            ent_inst_d[i] = mem2proc_data;
            ent_done_d[i] = 1'b1;
          end
        end
      end

      if (pop) begin
        ent_vld_d[head_q]  = 1'b0;
        ent_done_d[head_q] = 1'b0;
        head_d             = head_q + PTR_ONE;
      end

      if (accept) begin
        ent_pc_d[tail_q]   = fetch_pc_q;
        ent_tag_d[tail_q]  = mem2proc_response;
        ent_vld_d[tail_q]  = 1'b1;
        ent_done_d[tail_q] = 1'b0;
        tail_d             = tail_q + PTR_ONE;
        fetch_pc_d         = fetch_pc_q + 32'd4;
      end

      if (accept && !pop) begin
        count_d = count_q + CNT_ONE;
      end else if (!accept && pop) begin
        count_d = count_q - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      ent_vld_q  <= '0;
      ent_done_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_pc_q[i]   <= '0;
        ent_tag_q[i]  <= '0;
        ent_inst_q[i] <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      ent_vld_q  <= ent_vld_d;
      ent_done_q <= ent_done_d;
      ent_pc_q   <= ent_pc_d;
      ent_tag_q  <= ent_tag_d;
      ent_inst_q <= ent_inst_d;
    end
  end

endmodule

// File: doc/imem_prefetch_buffer.md
# imem_prefetch_buffer

In-order instruction prefetch queue between the instruction memory port and the processor's IF stage. It issues sequential word loads on the tagged, variable-latency memory bus and matches returning tags to reserved queue slots. It presents completed instructions to IF in program order with a valid/ready handshake. A redirect from the pipeline flushes the queue and restarts fetch at a new PC; memory returns that are still outstanding at the flush are discarded.

## Interface
- DEPTH, 4: queue entries (power of two, 2..8); bounds outstanding plus buffered fetches
- TAG_W, 4: memory tag width; tag 0 means no tag / not accepted
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- redirect_valid  in  1  flush queue, restart fetch at redirect_pc
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored (treated as 0)
- if_ready  in  1  IF consumes head entry this cycle
- out_valid  out  1  head entry holds a returned instruction
- out_pc  out  32  PC of head entry
- out_inst  out  32  instruction word of head entry
- proc2Imem_addr  out  32  load address (= fetch_pc)
- proc2Imem_command  out  2  0 = BUS_NONE, 1 = BUS_LOAD; 2 (BUS_STORE) never driven
- mem2proc_response  in  TAG_W  nonzero = load accepted this cycle, carrying its tag
- mem2proc_data  in  32  returned instruction word
- mem2proc_tag  in  TAG_W  nonzero = data for that tag valid this cycle

## Operation
- State:
  - fetch_pc
  - circular queue of DEPTH entries {pc, tag, inst, done}
  - head and tail pointers
  - count = number of reserved entries
- Issue: proc2Imem_command = BUS_LOAD when count < DEPTH and redirect_valid = 0; otherwise BUS_NONE. Command and address are combinational from registered state plus redirect_valid.
- Accept (response != 0 while issuing):
  - write {fetch_pc, response, done = 0} at tail
  - tail+1, count+1, fetch_pc += 4 (wraps modulo 2^32)
- Reject (response == 0 while issuing): no state change; the same address is retried next cycle.
- Return (mem2proc_tag != 0):
  - The reserved entry with tag == mem2proc_tag and done == 0 captures mem2proc_data and sets done = 1.
  - If no entry matches (stale tag from before a flush), the return is ignored.
  - The memory never reuses a tag while it is outstanding, so a stale tag cannot alias a live entry.
- Output: out_valid = done of head entry (when count > 0). out_pc and out_inst come from the head entry.
- Pop: out_valid & if_ready → head+1, count-1.
- Same-cycle accept and pop: count is unchanged; both pointers advance.
- Same-cycle return to the head entry: out_valid rises the following cycle, not combinationally.
- Redirect (highest priority):
  - Invalidate all entries; head = tail = count = 0.
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - A pop, return or response in the same cycle is ignored.
- Full (count == DEPTH): no issue. An entry freed by a pop allows issue in the next cycle.

## Timing
- Reset values:
  - out_valid 0, out_pc 0, out_inst 0
  - proc2Imem_command BUS_NONE, proc2Imem_addr 0
  - fetch_pc 0, count/head/tail 0, all done 0
- Reset may assert mid-operation. All state clears asynchronously. In-flight returns after reset release are stale and ignored.
- First load: proc2Imem_addr = 0 and BUS_LOAD in the first cycle after rst deasserts.
- Latency: data returned in cycle t → out_valid in cycle t+1 if that entry is the head.
- Redirect in cycle t → BUS_LOAD to redirect_pc in cycle t+1 (if memory accepts); out_valid = 0 in cycle t+1.
- Throughput: one issue, one return and one pop per cycle at most. Sustained 1 instr/cycle with enough tags and DEPTH ≥ memory latency/cycle.

## Test plan
- Reset release, memory accepts every cycle with tags 1,2,3,4 and data returned 3 cycles later, if_ready = 1 → loads at 0x0,0x4,0x8,0xC; outputs appear in order with out_pc 0x0..0xC; no gap after the first return.
- if_ready = 0 held, DEPTH = 4 → exactly 4 loads issued, then BUS_NONE. One pop → one new load to 0x10 in the next cycle.
- Out-of-order returns: tags 3,1,2 return in that order for PCs 0x0 (tag 1), 0x4 (tag 2), 0x8 (tag 3) → out_valid stays 0 until tag 1 returns; outputs are still 0x0, 0x4, 0x8 in order.
- response = 0 for 5 cycles → proc2Imem_addr holds 0x0 with BUS_LOAD throughout; fetch_pc advances only on the first nonzero response.
- Redirect to 0x1003 with two loads outstanding (tags 5,6) → next load goes to 0x1000. Late returns on tags 5 and 6 are ignored. First output is out_pc 0x1000.
- rst asserted mid-stream with out_valid = 1 → out_valid and command drop immediately. After release, fetch restarts at 0x0 and a pending stale tag is ignored.
